// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
// Imported by the loader top and its byte packer.
package imem_load_ctrl_pkg;

    localparam int DEPTH_DEF = 1024;
    localparam int AW_DEF    = 10;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_e;

    // A load length is usable only if it names at least one word and fits memory.
    function automatic logic len_ok(
        input int unsigned len,
        input int unsigned depth
    );
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// Assembles a little-endian 32-bit word from four accepted bytes.
// Tracks the byte position within the word being built.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        fire,
    input  logic [7:0]  data,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] word_q;
    logic [31:0] word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d  = 2'd0;
            word_d = 32'h0;
        end else if (fire) begin
            word_d[{cnt_q, 3'b000} +: 8] = data;
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign byte_cnt = cnt_q;
    assign word     = word_q;
    assign last     = fire && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Holds the core in reset while a program is streamed into instruction
// memory byte by byte, then releases it and gates its fetch path.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          run_start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_instr,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata,
    output logic          core_hold,
    output logic          load_done,
    output logic          err_len,
    output logic          busy
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    state_e      state_q;
    state_e      state_d;
    logic [AW:0] len_q;
    logic [AW:0] len_d;
    logic [AW:0] word_cnt_q;
    logic [AW:0] word_cnt_d;

    logic        start_ok;
    logic        pk_clr;
    logic        pk_fire;
    logic        pk_last;
    logic [1:0]  pk_byte_cnt;
    logic [31:0] pk_word;
    logic        err_c;
    logic        done_c;
    logic        we_c;
    logic        unused_addr_hi;

    assign start_ok = load_start && len_ok(32'(load_len), DEPTH);
    assign pk_fire  = byte_valid && byte_ready;

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pk_clr),
        .fire     (pk_fire),
        .data     (byte_data),
        .byte_cnt (pk_byte_cnt),
        .word     (pk_word),
        .last     (pk_last)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        pk_clr     = 1'b0;
        err_c      = 1'b0;
        done_c     = 1'b0;
        we_c       = 1'b0;
        unique case (state_q)
            HOLD, RUN: begin
                if (load_start) begin
                    if (start_ok) begin
                        state_d    = RECV;
                        len_d      = load_len;
                        word_cnt_d = '0;
                        pk_clr     = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end else if (run_start && (state_q == HOLD)) begin
                    state_d = RUN;
                end
            end
            RECV: begin
                if (pk_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                we_c       = 1'b1;
                word_cnt_d = word_cnt_q + ONE;
                if (word_cnt_q == (len_q - ONE)) begin
                    state_d = RUN;
                    done_c  = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= HOLD;
            len_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is asserted, even before the first edge.
    assign core_hold  = !rst || (state_q != RUN);
    assign busy       = rst && ((state_q == RECV) || (state_q == WRITE));
    assign byte_ready = rst && (state_q == RECV);
    assign mem_we     = rst && we_c;
    assign load_done  = rst && done_c;
    assign err_len    = rst && err_c;

    assign mem_waddr = word_cnt_q[AW-1:0];
    assign mem_wdata = pk_word;

    assign mem_raddr   = fetch_addr[AW+1:2];
    assign fetch_instr = (!core_hold && (fetch_addr[1:0] == 2'b00))
                         ? mem_rdata : 32'h0;

    assign unused_addr_hi = ^{fetch_addr[31:AW+2], pk_byte_cnt};

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: control/fetch vector tables,
// directed load sequences and randomized loads against a word-level model.
module tb_imem_load_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          run_start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_instr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic          core_hold;
    logic          load_done;
    logic          err_len;
    logic          busy;

    imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_len    (load_len),
        .run_start   (run_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .core_hold   (core_hold),
        .load_done   (load_done),
        .err_len     (err_len),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00009E37);
    endfunction

    // Environment memory (written by the DUT) and the model's view of it.
    logic [31:0] tb_mem [DEPTH];
    logic [31:0] mexp   [DEPTH];
    logic        init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= pat(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            tb_mem[mem_waddr] <= mem_wdata;
        end
    end

    assign mem_rdata = tb_mem[mem_raddr];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t obs[$];
    int  done_cnt = 0;
    int  err_cnt  = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            obs.push_back('{mem_waddr, mem_wdata});
            check("byte_ready_in_write", {31'h0, byte_ready}, 32'h0);
        end
        if (load_done) done_cnt++;
        if (err_len) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_start = 1'b0;
        run_start  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h0;
    endtask

    task automatic begin_load();
        obs.delete();
        done_cnt = 0;
    endtask

    // Issue a load and stream nbytes of bq; optionally wait for the core release.
    task automatic send_load(input int len, input logic [7:0] bq[$],
                             input int gap, input bit noise,
                             input int nbytes, input bit wait_end);
        int  guard;
        bit  fired;
        int  n;
        load_start = 1'b1;
        load_len   = (AW+1)'(len);
        tick();
        load_start = 1'b0;
        @(negedge clk);
        check("hold_after_start", {31'h0, core_hold}, 32'h1);
        check("busy_after_start", {31'h0, busy}, 32'h1);
        tick();
        for (int k = 0; k < nbytes; k++) begin
            fired = 1'b0;
            guard = 0;
            while (!fired) begin
                byte_valid = ($urandom_range(99) >= gap);
                byte_data  = byte_valid ? bq[k] : 8'($urandom);
                if (noise) begin
                    load_start = ($urandom_range(3) == 0);
                    load_len   = (AW+1)'($urandom);
                    run_start  = ($urandom_range(3) == 0);
                end
                @(negedge clk);
                fired = byte_valid && byte_ready;
                tick();
                guard++;
                if (!fired && guard > 300) begin
                    check("byte_accept_timeout", 32'h0, 32'h1);
                    clear_inputs();
                    return;
                end
            end
        end
        clear_inputs();
        if (wait_end) begin
            n = 0;
            @(negedge clk);
            while (core_hold && n < 20) begin
                tick();
                @(negedge clk);
                n++;
            end
            check("run_reached", {31'h0, core_hold}, 32'h0);
            tick();
        end
    endtask

    // Compare observed writes with words built from the byte list.
    task automatic finish_load(input int len, input logic [7:0] bq[$]);
        logic [31:0] w;
        check("write_count", 32'(obs.size()), 32'(len));
        check("load_done_count", 32'(done_cnt), 32'h1);
        for (int i = 0; i < len; i++) begin
            w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
            mexp[i] = w;
            if (i < obs.size()) begin
                check("write_addr", 32'(obs[i].a), 32'(i));
                check("write_data", obs[i].d, w);
            end
        end
    endtask

    task automatic fetch_check(input logic [31:0] addr);
        logic [AW-1:0] idx;
        logic [31:0]   exp;
        idx = addr[AW+1:2];
        fetch_addr = addr;
        @(negedge clk);
        exp = (core_hold || addr[1:0] != 2'b00) ? 32'h0 : mexp[idx];
        check("mem_raddr", 32'(mem_raddr), 32'(idx));
        check("fetch_instr", fetch_instr, exp);
        tick();
    endtask

    typedef struct {
        logic [AW:0] len;
        logic        ls;
        logic        rs;
        logic        exp_err;
        logic        exp_hold;
    } ctl_vec_t;

    typedef struct {
        logic [31:0]   addr;
        logic [AW-1:0] exp_raddr;
        logic          exp_zero;
    } fetch_vec_t;

    ctl_vec_t   ctl_tab[5];
    fetch_vec_t f_tab[5];
    logic [7:0] bq[$];
    logic [7:0] spec_bytes[$];
    int         len;

    initial begin
        ctl_tab[0] = '{11'd0,    1'b1, 1'b0, 1'b1, 1'b1};
        ctl_tab[1] = '{11'd1025, 1'b1, 1'b0, 1'b1, 1'b1};
        ctl_tab[2] = '{11'd2047, 1'b1, 1'b0, 1'b1, 1'b1};
        ctl_tab[3] = '{11'd0,    1'b1, 1'b1, 1'b1, 1'b1};
        ctl_tab[4] = '{11'd5,    1'b0, 1'b0, 1'b0, 1'b1};

        f_tab[0] = '{32'h0000_1004, 10'd1,    1'b0};
        f_tab[1] = '{32'h0000_0006, 10'd1,    1'b1};
        f_tab[2] = '{32'h0000_0FFC, 10'd1023, 1'b0};
        f_tab[3] = '{32'hFFFF_FFF0, 10'd1020, 1'b0};
        f_tab[4] = '{32'h0000_0003, 10'd0,    1'b1};

        spec_bytes = '{8'h13, 8'h0A, 8'h41, 8'h01, 8'h33, 8'h83, 8'h20, 8'h00};

        for (int i = 0; i < DEPTH; i++) mexp[i] = pat(i);

        // Reset with every request input active.
        rst        = 1'b0;
        load_start = 1'b1;
        load_len   = 11'd5;
        run_start  = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        fetch_addr = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_core_hold", {31'h0, core_hold}, 32'h1);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_byte_ready", {31'h0, byte_ready}, 32'h0);
        check("rst_load_done", {31'h0, load_done}, 32'h0);
        check("rst_err_len", {31'h0, err_len}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_fetch_instr", fetch_instr, 32'h0);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();

        // Idle HOLD: fetches return zero.
        for (int i = 0; i < 4; i++) fetch_check($urandom & 32'hFFFF_FFFC);

        // Length-error and idle vectors in HOLD.
        begin_load();
        err_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            load_len   = ctl_tab[i].len;
            load_start = ctl_tab[i].ls;
            run_start  = ctl_tab[i].rs;
            @(negedge clk);
            check("ctl_err_len", {31'h0, err_len}, {31'h0, ctl_tab[i].exp_err});
            tick();
            clear_inputs();
            @(negedge clk);
            check("ctl_hold_next", {31'h0, core_hold}, {31'h0, ctl_tab[i].exp_hold});
            check("ctl_busy_next", {31'h0, busy}, 32'h0);
            tick();
        end
        check("ctl_err_pulses", 32'(err_cnt), 32'd4);
        check("ctl_no_writes", 32'(obs.size()), 32'h0);

        // Release without loading.
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        @(negedge clk);
        check("run_core_hold", {31'h0, core_hold}, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            fetch_addr = f_tab[i].addr;
            @(negedge clk);
            check("ftab_raddr", 32'(mem_raddr), 32'(f_tab[i].exp_raddr));
            check("ftab_instr", fetch_instr,
                  f_tab[i].exp_zero ? 32'h0 : mexp[f_tab[i].exp_raddr]);
            tick();
        end

        // Length error in RUN leaves the core running.
        err_cnt    = 0;
        load_start = 1'b1;
        load_len   = 11'd1025;
        @(negedge clk);
        check("run_err_len", {31'h0, err_len}, 32'h1);
        tick();
        clear_inputs();
        @(negedge clk);
        check("run_err_hold", {31'h0, core_hold}, 32'h0);
        check("run_err_once", 32'(err_cnt), 32'h1);
        tick();

        // Reference program, issued from RUN, then again with stream gaps.
        begin_load();
        send_load(2, spec_bytes, 0, 1'b0, 8, 1'b1);
        check("ref_word0", obs.size() > 0 ? obs[0].d : 32'hX, 32'h01410A13);
        check("ref_word1", obs.size() > 1 ? obs[1].d : 32'hX, 32'h00208333);
        finish_load(2, spec_bytes);
        begin_load();
        send_load(2, spec_bytes, 60, 1'b0, 8, 1'b1);
        finish_load(2, spec_bytes);
        fetch_check(32'h0000_0000);
        fetch_check(32'h0000_0004);

        // Reset after 5 bytes of a 3-word load.
        begin_load();
        bq.delete();
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        send_load(3, bq, 0, 1'b0, 5, 1'b0);
        mexp[0] = {bq[3], bq[2], bq[1], bq[0]};
        rst        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        tick();
        @(negedge clk);
        check("midrst_hold", {31'h0, core_hold}, 32'h1);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_ready", {31'h0, byte_ready}, 32'h0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        byte_valid = 1'b0;
        check("midrst_writes", 32'(obs.size()), 32'h1);

        // Fresh load from HOLD with load_start and run_start together.
        begin_load();
        load_start = 1'b1;
        run_start  = 1'b1;
        load_len   = 11'd1;
        tick();
        clear_inputs();
        @(negedge clk);
        check("prio_busy", {31'h0, busy}, 32'h1);
        tick();
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        send_load(1, bq, 30, 1'b0, 4, 1'b1);
        finish_load(1, bq);

        // Randomized loads with request noise during the stream.
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(6, 1);
            bq.delete();
            for (int i = 0; i < 4 * len; i++) bq.push_back(8'($urandom));
            begin_load();
            send_load(len, bq, $urandom_range(60), 1'b1, 4 * len, 1'b1);
            finish_load(len, bq);
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(1) == 0)
                    fetch_check(32'($urandom_range(7)) << 2);
                else
                    fetch_check($urandom);
            end
        end

        // Full-depth load.
        bq.delete();
        for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'($urandom));
        begin_load();
        send_load(DEPTH, bq, 0, 1'b0, 4 * DEPTH, 1'b1);
        finish_load(DEPTH, bq);
        for (int i = 0; i < 8; i++) fetch_check($urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory size in 32-bit words.
REQ-002 SHALL have parameter AW, default 10, meaning word-address width, with DEPTH = 2**AW.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port load_start, input, 1 bit: single-cycle request to begin a program load.
REQ-006 SHALL have port load_len, input, AW+1 bits: number of words to load, sampled with load_start.
REQ-007 SHALL have port run_start, input, 1 bit: release core without loading; used when memory is preinitialized.
REQ-008 SHALL have ports byte_valid (input, 1), byte_data (input, 8) and byte_ready (output, 1): the loader byte stream.
REQ-009 SHALL have port fetch_addr, input, 32 bits: core PC byte address.
REQ-010 SHALL have port fetch_instr, output, 32 bits: instruction returned to the core.
REQ-011 SHALL have ports mem_we (output, 1), mem_waddr (output, AW) and mem_wdata (output, 32): memory write port.
REQ-012 SHALL have ports mem_raddr (output, AW) and mem_rdata (input, 32): combinational-read memory port.
REQ-013 SHALL have outputs core_hold, load_done, err_len and busy, each 1 bit.

Function
REQ-014 SHALL implement states HOLD, RECV, WRITE and RUN.
REQ-015 HOLD: core_hold=1; load_start with a valid length -> RECV; run_start alone -> RUN.
REQ-016 HOLD or RUN: load_start with load_len==0 or load_len>DEPTH SHALL pulse err_len for 1 cycle and leave the state unchanged.
REQ-017 A valid load_start SHALL latch load_len, clear word_cnt and byte_cnt, and force core_hold=1 from the next cycle, including when issued from RUN.
REQ-018 RECV: byte_ready=1; a byte transfers when byte_valid && byte_ready.
REQ-019 Byte i of a word (i=0..3) SHALL land in bits [8i+7:8i], little-endian; byte_cnt wraps 3->0.
REQ-020 The 4th accepted byte SHALL move the FSM to WRITE; byte_ready=0 in every state except RECV.
REQ-021 WRITE: mem_we=1 for exactly 1 cycle, with mem_waddr=word_cnt and mem_wdata=the assembled word; word_cnt then increments.
REQ-022 WRITE: if word_cnt==len-1, SHALL go to RUN and pulse load_done in that cycle; otherwise SHALL return to RECV.
REQ-023 RUN: core_hold=0 and busy=0; busy=1 in RECV and WRITE.
REQ-024 mem_raddr SHALL always equal fetch_addr[AW+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH.
REQ-025 fetch_instr SHALL be mem_rdata, combinational, when core_hold=0; it SHALL be 32'h0 when core_hold=1 or fetch_addr[1:0]!=0.
REQ-026 load_start and run_start SHALL be ignored in RECV and WRITE; load_start has priority over run_start in the same cycle.
REQ-027 A stalled byte stream SHALL hold the state and partial word indefinitely; there is no timeout.

Reset
REQ-028 When rst==0 at a clock edge, the FSM SHALL go to HOLD and word_cnt, byte_cnt and the word buffer SHALL be cleared, including mid-load.
REQ-029 During and after reset, outputs SHALL be: core_hold=1, mem_we=0, byte_ready=0, load_done=0, err_len=0, busy=0, fetch_instr=0.

Structure
REQ-030 A shared package SHALL hold the state enum (HOLD, RECV, WRITE, RUN) and the default DEPTH/AW constants.
REQ-031 A sub-module byte_packer SHALL perform byte-to-word assembly and byte_cnt; the FSM, counters and fetch gating stay in imem_load_ctrl.

Verification
REQ-032 Reset then idle: core_hold=1 and fetch_instr=0 for any fetch_addr; run_start -> core_hold=0 next cycle and fetch_instr=mem_rdata.
REQ-033 load_start, load_len=2, bytes 13,0A,41,01,33,83,20,00 -> writes 0x01410A13 @0 and 0x00208333 @1, load_done pulses once, then RUN.
REQ-034 Valid bursts with gaps on byte_valid -> identical memory contents; byte_ready low during each WRITE cycle.
REQ-035 load_len=0, and load_len=1025 -> err_len pulses once each, state unchanged, no mem_we.
REQ-036 rst=0 after 5 bytes of a 3-word load -> HOLD, no further mem_we; a fresh load then writes from address 0.
REQ-037 RUN with fetch_addr=0x1004 -> mem_raddr=1 (wrap); fetch_addr=0x6 -> fetch_instr=0; load_start in RUN -> core_hold=1 next cycle.
